// File: rtl/vend_txn_ctrl.sv
// rtl/vend_txn_ctrl.sv - vending transaction controller: credit, price/stock lookup, dispense and change handshakes (VEND_TIMEOUT_EN adds CREDIT idle auto-refund)
module vend_txn_ctrl #(
    parameter int  MAX_NOTE_VAL   = 100,
    parameter int  MAX_ITEMS      = 1024,
    parameter int  MAX_BALANCE    = 1000,
    parameter int  TIMEOUT_CYCLES = 1000000,
    localparam int CW             = $clog2(MAX_NOTE_VAL) + 1,
    localparam int IW             = $clog2(MAX_ITEMS),
    localparam int BW             = $clog2(MAX_BALANCE + 1)
) (
    input  logic          clk_fsm,            // single clock
    input  logic          rstn,               // synchronous, active-low
    input  logic          currency_valid,     // note inserted (pulse)
    input  logic [CW-1:0] currency_value,     // note value
    input  logic          item_select_valid,  // item selected (pulse)
    input  logic [IW-1:0] item_select,        // item index
    input  logic          cancel,             // refund request (pulse)
    output logic          price_rd_en,        // table read strobe
    output logic [IW-1:0] price_rd_addr,      // table address
    input  logic [BW-1:0] price_rd_data,      // price, cycle after strobe
    input  logic          stock_rd_data,      // in stock, cycle after strobe
    output logic          dispense_valid,     // dispense handshake
    input  logic          dispense_ready,
    output logic [IW-1:0] dispense_item,      // item being dispensed
    output logic          change_valid,       // change handshake
    input  logic          change_ready,
    output logic [BW-1:0] change_value,       // change amount
    output logic [BW-1:0] balance,            // current credit
    output logic          currency_reject,    // note refused (pulse)
    output logic          vend_error,         // purchase refused (pulse)
    output logic          busy                // LOOKUP/EVAL/DISPENSE/CHANGE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CREDIT,
        S_LOOKUP,
        S_EVAL,
        S_DISPENSE,
        S_CHANGE
    } state_t;

    state_t        state;
    logic [IW-1:0] item_q;
    logic [BW:0]   sum_ext;
    logic          note_nz;
    logic          note_fits;
    logic          note_ok;
    logic          timeout_hit;

    // One extra bit so an overflowing sum is still compared correctly.
    assign sum_ext   = (BW+1)'(balance) + (BW+1)'(currency_value);
    assign note_nz   = (currency_value != '0);
    assign note_fits = (sum_ext <= (BW+1)'(MAX_BALANCE));
    assign note_ok   = currency_valid && note_nz && note_fits;

    // The latched item addresses the table and names the dispensed item.
    assign price_rd_addr = item_q;
    assign dispense_item = item_q;

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    // Zero outside CREDIT, so entering CREDIT always starts a fresh count.
    always_ff @(posedge clk_fsm) begin
        if (!rstn || state != S_CREDIT || (note_ok && !cancel)) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    assign timeout_hit = (state == S_CREDIT) && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    // Never fires in this build: CREDIT waits indefinitely.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk_fsm) begin
        if (!rstn) begin
            state           <= S_IDLE;
            item_q          <= '0;
            balance         <= '0;
            price_rd_en     <= 1'b0;
            dispense_valid  <= 1'b0;
            change_valid    <= 1'b0;
            change_value    <= '0;
            currency_reject <= 1'b0;
            vend_error      <= 1'b0;
            busy            <= 1'b0;
        end else begin
            currency_reject <= 1'b0;
            vend_error      <= 1'b0;
            price_rd_en     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (currency_valid && note_nz) begin
                        if (note_fits) begin
                            balance <= sum_ext[BW-1:0];
                            state   <= S_CREDIT;
                        end else begin
                            currency_reject <= 1'b1;
                        end
                    end
                end

                S_CREDIT: begin
                    if (cancel) begin
                        currency_reject <= currency_valid && note_nz;
                        change_valid    <= 1'b1;
                        change_value    <= balance;
                        busy            <= 1'b1;
                        state           <= S_CHANGE;
                    end else if (note_ok) begin
                        balance <= sum_ext[BW-1:0];
                    end else if (timeout_hit) begin
                        currency_reject <= currency_valid && note_nz;
                        change_valid    <= 1'b1;
                        change_value    <= balance;
                        busy            <= 1'b1;
                        state           <= S_CHANGE;
                    end else if (currency_valid && note_nz) begin
                        // Refused note still wins over a same-cycle select.
                        currency_reject <= 1'b1;
                    end else if (item_select_valid) begin
                        item_q      <= item_select;
                        price_rd_en <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_LOOKUP;
                    end
                end

                S_LOOKUP: begin
                    currency_reject <= currency_valid;
                    state           <= S_EVAL;
                end

                S_EVAL: begin
                    currency_reject <= currency_valid;
                    if (!stock_rd_data || (balance < price_rd_data)) begin
                        vend_error <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_CREDIT;
                    end else begin
                        balance        <= balance - price_rd_data;
                        dispense_valid <= 1'b1;
                        state          <= S_DISPENSE;
                    end
                end

                S_DISPENSE: begin
                    currency_reject <= currency_valid;
                    if (dispense_ready) begin
                        dispense_valid <= 1'b0;
                        if (balance != '0) begin
                            change_valid <= 1'b1;
                            change_value <= balance;
                            state        <= S_CHANGE;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end

                S_CHANGE: begin
                    currency_reject <= currency_valid;
                    if (change_ready) begin
                        change_valid <= 1'b0;
                        change_value <= '0;
                        balance      <= '0;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// tb/tb_vend_txn_ctrl.sv - self-checking bench for vend_txn_ctrl
module tb_vend_txn_ctrl;

    localparam int MAX_NOTE_VAL = 100;
    localparam int MAX_ITEMS    = 1024;
    localparam int MAX_BALANCE  = 1000;
    localparam int TOC          = 16;
    localparam int CW           = $clog2(MAX_NOTE_VAL) + 1;
    localparam int IW           = $clog2(MAX_ITEMS);
    localparam int BW           = $clog2(MAX_BALANCE + 1);

    logic          clk_fsm = 1'b0;
    logic          rstn = 1'b0;
    logic          currency_valid = 1'b0;
    logic [CW-1:0] currency_value = '0;
    logic          item_select_valid = 1'b0;
    logic [IW-1:0] item_select = '0;
    logic          cancel = 1'b0;
    logic          price_rd_en;
    logic [IW-1:0] price_rd_addr;
    logic [BW-1:0] price_rd_data;
    logic          stock_rd_data;
    logic          dispense_valid;
    logic          dispense_ready = 1'b0;
    logic [IW-1:0] dispense_item;
    logic          change_valid;
    logic          change_ready = 1'b0;
    logic [BW-1:0] change_value;
    logic [BW-1:0] balance;
    logic          currency_reject;
    logic          vend_error;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int bal;

    logic [BW-1:0] ptbl [MAX_ITEMS];
    logic          stbl [MAX_ITEMS];

    vend_txn_ctrl #(
        .MAX_NOTE_VAL   (MAX_NOTE_VAL),
        .MAX_ITEMS      (MAX_ITEMS),
        .MAX_BALANCE    (MAX_BALANCE),
        .TIMEOUT_CYCLES (TOC)
    ) dut (
        .clk_fsm           (clk_fsm),
        .rstn              (rstn),
        .currency_valid    (currency_valid),
        .currency_value    (currency_value),
        .item_select_valid (item_select_valid),
        .item_select       (item_select),
        .cancel            (cancel),
        .price_rd_en       (price_rd_en),
        .price_rd_addr     (price_rd_addr),
        .price_rd_data     (price_rd_data),
        .stock_rd_data     (stock_rd_data),
        .dispense_valid    (dispense_valid),
        .dispense_ready    (dispense_ready),
        .dispense_item     (dispense_item),
        .change_valid      (change_valid),
        .change_ready      (change_ready),
        .change_value      (change_value),
        .balance           (balance),
        .currency_reject   (currency_reject),
        .vend_error        (vend_error),
        .busy              (busy)
    );

    always #5 clk_fsm = ~clk_fsm;

    // Price/stock table: one-cycle read latency, garbage when not strobed.
    always @(posedge clk_fsm) begin
        if (price_rd_en) begin
            price_rd_data <= ptbl[price_rd_addr];
            stock_rd_data <= stbl[price_rd_addr];
        end else begin
            price_rd_data <= BW'($urandom);
            stock_rd_data <= 1'($urandom);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk_fsm);
    endtask

    always @(negedge clk_fsm) begin
        if (rstn === 1'b1) chk("valid_exclusive", 32'(dispense_valid & change_valid), 0);
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_price_rd_en"}, price_rd_en, 0);
        chk({tag, "_price_rd_addr"}, price_rd_addr, 0);
        chk({tag, "_dispense_valid"}, dispense_valid, 0);
        chk({tag, "_dispense_item"}, dispense_item, 0);
        chk({tag, "_change_valid"}, change_valid, 0);
        chk({tag, "_change_value"}, change_value, 0);
        chk({tag, "_balance"}, balance, 0);
        chk({tag, "_currency_reject"}, currency_reject, 0);
        chk({tag, "_vend_error"}, vend_error, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_note(input int v, input bit exp_rej, input int exp_bal);
        currency_valid = 1'b1;
        currency_value = CW'(v);
        cyc();
        currency_valid = 1'b0;
        currency_value = '0;
        chk("note_reject", currency_reject, exp_rej);
        chk("note_balance", balance, exp_bal);
    endtask

    task automatic hs_chg(input int d, input int val);
        for (int i = 0; i < d; i++) begin
            chk("chg_held", change_valid, 1);
            cyc();
        end
        chk("chg_valid_at_hs", change_valid, 1);
        chk("chg_value", change_value, val);
        change_ready = 1'b1;
        cyc();
        change_ready = 1'b0;
        chk("chg_drop", change_valid, 0);
        chk("chg_bal_zero", balance, 0);
        chk("chg_not_busy", busy, 0);
    endtask

    task automatic hs_disp(input int d, input int item, input int exp_bal, input bit inj, input int injv);
        int hi;
        hi = 0;
        for (int i = 0; i < d; i++) begin
            if (dispense_valid === 1'b1) hi++;
            if (inj && i == 0) begin
                currency_valid = 1'b1;
                currency_value = CW'(injv);
            end
            cyc();
            if (inj && i == 0) begin
                currency_valid = 1'b0;
                currency_value = '0;
                chk("busy_note_reject", currency_reject, 1);
                chk("busy_note_balance", balance, exp_bal);
            end
        end
        chk("disp_held_cycles", hi, d);
        chk("disp_valid_at_hs", dispense_valid, 1);
        chk("disp_item", dispense_item, item);
        dispense_ready = 1'b1;
        cyc();
        dispense_ready = 1'b0;
        chk("disp_drop", dispense_valid, 0);
    endtask

    task automatic idle_select(input int item);
        item_select_valid = 1'b1;
        item_select = IW'(item);
        cyc();
        item_select_valid = 1'b0;
        chk("idle_sel_no_read", price_rd_en, 0);
        chk("idle_sel_not_busy", busy, 0);
    endtask

    task automatic do_select(input int item, input int price, input bit stock, input bit exp_err,
                             input int exp_bal, input int exp_chg, input int dd, input int dc,
                             input bit inj, input int injv);
        ptbl[item] = BW'(price);
        stbl[item] = stock;
        item_select_valid = 1'b1;
        item_select = IW'(item);
        cyc();
        item_select_valid = 1'b0;
        chk("lookup_rd_en", price_rd_en, 1);
        chk("lookup_rd_addr", price_rd_addr, item);
        chk("lookup_busy", busy, 1);
        cyc();
        chk("eval_rd_en_low", price_rd_en, 0);
        cyc();
        chk("n3_vend_error", vend_error, exp_err);
        chk("n3_dispense_valid", dispense_valid, !exp_err);
        chk("n3_balance", balance, exp_bal);
        if (exp_err) begin
            chk("err_not_busy", busy, 0);
            cyc();
            chk("err_pulse_one", vend_error, 0);
        end else begin
            hs_disp(dd, item, exp_bal, inj, injv);
            if (exp_chg > 0) begin
                chk("post_disp_change_valid", change_valid, 1);
                chk("post_disp_change_value", change_value, exp_chg);
                hs_chg(dc, exp_chg);
            end else begin
                chk("no_change_valid", change_valid, 0);
                chk("no_change_idle", busy, 0);
                chk("no_change_bal", balance, 0);
            end
        end
    endtask

    task automatic do_cancel(input int v, input int exp_chg, input int d);
        cancel = 1'b1;
        currency_valid = (v != 0);
        currency_value = CW'(v);
        cyc();
        cancel = 1'b0;
        currency_valid = 1'b0;
        currency_value = '0;
        if (exp_chg == 0) begin
            chk("idle_cancel_ignored", change_valid, 0);
            chk("idle_cancel_not_busy", busy, 0);
        end else begin
            chk("cancel_note_reject", currency_reject, v != 0);
            chk("cancel_change_valid", change_valid, 1);
            chk("cancel_change_value", change_value, exp_chg);
            chk("cancel_balance", balance, exp_chg);
            hs_chg(d, exp_chg);
        end
    endtask

    typedef struct {
        int n1;
        int n2;
        int item;
        int price;
        bit stock;
        bit exp_err;
        int exp_bal;
        int exp_chg;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{50, 20, 5, 60, 1'b1, 1'b0, 10, 10};
        vecs[1] = '{30, 0, 7, 40, 1'b1, 1'b1, 30, 0};
        vecs[2] = '{30, 0, 9, 20, 1'b0, 1'b1, 30, 0};
        vecs[3] = '{40, 60, 1023, 100, 1'b1, 1'b0, 0, 0};
        vecs[4] = '{100, 100, 0, 0, 1'b1, 1'b0, 200, 200};
        vecs[5] = '{25, 0, 3, 26, 1'b1, 1'b1, 25, 0};
        vecs[6] = '{25, 0, 4, 25, 1'b1, 1'b0, 0, 0};

        cyc();
        cyc();
        chk_all_zero("reset");
        rstn = 1'b1;
        cyc();
        chk_all_zero("post_reset");

        // Zero-value note, select and cancel are all ignored in IDLE.
        do_note(0, 0, 0);
        idle_select(11);
        do_cancel(0, 0, 0);

        for (int i = 0; i < 7; i++) begin
            do_note(vecs[i].n1, 0, vecs[i].n1);
            if (vecs[i].n2 != 0) do_note(vecs[i].n2, 0, vecs[i].n1 + vecs[i].n2);
            do_select(vecs[i].item, vecs[i].price, vecs[i].stock, vecs[i].exp_err,
                      vecs[i].exp_bal, vecs[i].exp_chg, i % 3, (i + 1) % 3, 1'b0, 0);
            if (vecs[i].exp_err) do_cancel(0, vecs[i].exp_bal, 1);
        end

        // Credit ceiling: 950 + 100 refused, 950 + 50 lands exactly on the cap.
        for (int i = 0; i < 9; i++) do_note(100, 0, (i + 1) * 100);
        do_note(50, 0, 950);
        do_note(100, 1, 950);
        do_note(50, 0, 1000);
        do_note(1, 1, 1000);
        do_cancel(0, 1000, 2);

        // Cancel beats a same-cycle note.
        do_note(50, 0, 50);
        do_note(20, 0, 70);
        do_cancel(10, 70, 3);

        // Note during a stalled dispense.
        do_note(100, 0, 100);
        do_select(21, 30, 1'b1, 1'b0, 70, 70, 5, 0, 1'b1, 10);

        // Reset mid-dispense drops the handshake and the credit.
        do_note(50, 0, 50);
        do_note(30, 0, 80);
        ptbl[12] = BW'(10);
        stbl[12] = 1'b1;
        item_select_valid = 1'b1;
        item_select = IW'(12);
        cyc();
        item_select_valid = 1'b0;
        cyc();
        cyc();
        chk("pre_reset_dispensing", dispense_valid, 1);
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        chk_all_zero("mid_reset");
        idle_select(12);

        // Random operations against a transaction-level model.
        bal = 0;
        for (int n = 0; n < 120; n++) begin
            int op, v, item, price, dd, dc;
            bit stock, err, inj;
            op = $urandom_range(0, 9);
            v  = $urandom_range(1, MAX_NOTE_VAL);
            dd = $urandom_range(0, 3);
            dc = $urandom_range(0, 3);
            if (op <= 4) begin
                if (bal + v <= MAX_BALANCE) begin
                    bal += v;
                    do_note(v, 0, bal);
                end else begin
                    do_note(v, 1, bal);
                end
            end else if (op <= 7) begin
                item  = $urandom_range(0, MAX_ITEMS - 1);
                price = $urandom_range(0, 400);
                stock = ($urandom_range(0, 4) != 0);
                if (bal == 0) begin
                    idle_select(item);
                end else begin
                    err = !stock || (bal < price);
                    inj = (dd > 0) && ($urandom_range(0, 1) == 1);
                    if (err) begin
                        do_select(item, price, stock, 1'b1, bal, 0, dd, dc, 1'b0, 0);
                    end else begin
                        do_select(item, price, stock, 1'b0, bal - price, bal - price, dd, dc, inj, v);
                        bal = 0;
                    end
                end
            end else if (op == 8) begin
                do_cancel(0, bal, dc);
                bal = 0;
            end else if (bal > 0) begin
                do_cancel(v, bal, dc);
                bal = 0;
            end
        end

`ifdef VEND_TIMEOUT_EN
        do_note(40, 0, 40);
        for (int i = 0; i < TOC - 1; i++) cyc();
        chk("timeout_not_yet", change_valid, 0);
        cyc();
        chk("timeout_change_valid", change_valid, 1);
        chk("timeout_change_value", change_value, 40);
        hs_chg(0, 40);

        do_note(40, 0, 40);
        for (int i = 0; i < TOC - 1; i++) cyc();
        do_note(10, 0, 50);
        for (int i = 0; i < TOC - 1; i++) cyc();
        chk("timeout_restart_not_yet", change_valid, 0);
        cyc();
        chk("timeout_restart_change_valid", change_valid, 1);
        chk("timeout_restart_change_value", change_value, 50);
        hs_chg(1, 50);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vend_txn_ctrl.md
# vend_txn_ctrl

Transaction controller for the vending machine, in the `clk_fsm` domain directly downstream of the input synchronizer. It consumes synchronized currency and item-select pulses and accumulates credit. For each purchase it sequences a price/stock lookup, then a dispense handshake, then a change-return handshake. It is the single owner of the customer balance.

## Interface
Parameters:
- `MAX_NOTE_VAL`, 100, largest note/coin value; `CW = $clog2(MAX_NOTE_VAL)+1`
- `MAX_ITEMS`, 1024, item slots; `IW = $clog2(MAX_ITEMS)`
- `MAX_BALANCE`, 1000, credit ceiling; `BW = $clog2(MAX_BALANCE+1)`
- `TIMEOUT_CYCLES`, 1000000, idle cycles in CREDIT before auto-refund (only with `VEND_TIMEOUT_EN`)

Ports:
- `clk_fsm`  in  1  the block's single clock
- `rstn`  in  1  synchronous, active-low reset
- `currency_valid`  in  1  one-cycle pulse, a note has been inserted
- `currency_value`  in  CW  note value, qualified by `currency_valid`
- `item_select_valid`  in  1  one-cycle pulse, an item has been selected
- `item_select`  in  IW  item index, qualified by `item_select_valid`
- `cancel`  in  1  one-cycle refund request
- `price_rd_en`  out  1  price/stock table read strobe
- `price_rd_addr`  out  IW  table address
- `price_rd_data`  in  BW  item price, valid the cycle after `price_rd_en`
- `stock_rd_data`  in  1  item in stock, valid the cycle after `price_rd_en`
- `dispense_valid` / `dispense_ready`  out/in  1  dispense handshake
- `dispense_item`  out  IW  item to dispense
- `change_valid` / `change_ready`  out/in  1  change handshake
- `change_value`  out  BW  change amount
- `balance`  out  BW  current credit
- `currency_reject`  out  1  one-cycle pulse, note refused
- `vend_error`  out  1  one-cycle pulse, purchase refused
- `busy`  out  1  high in LOOKUP, EVAL, DISPENSE and CHANGE

## Operation
States: IDLE, CREDIT, LOOKUP, EVAL, DISPENSE, CHANGE.

- **IDLE** (balance 0):
  - Accepted currency: move to CREDIT.
  - `item_select_valid` and `cancel` are ignored.
- **Currency acceptance** (IDLE/CREDIT):
  - Compute `balance + currency_value` at BW+1 bits.
  - If the sum is ≤ MAX_BALANCE, accept and update `balance`. Otherwise pulse `currency_reject` and leave `balance` unchanged.
  - A `currency_value` of 0 is ignored with no pulse.
- **CREDIT** priority, highest first:
  - `cancel`: go to CHANGE. A simultaneous note is rejected.
  - Currency: accept as above. A simultaneous `item_select_valid` is dropped silently.
  - `item_select_valid`: latch `item_select` and go to LOOKUP.
- **LOOKUP**: one cycle.
  - `price_rd_en=1`, `price_rd_addr` holds the latched item; go to EVAL.
- **EVAL**: one cycle, samples the table outputs.
  - `!stock_rd_data`: pulse `vend_error`, return to CREDIT.
  - Else if `balance < price_rd_data`: pulse `vend_error`, return to CREDIT.
  - Else: `balance <= balance - price`, go to DISPENSE.
- **DISPENSE**:
  - Hold `dispense_valid=1` with `dispense_item` stable until `dispense_ready`.
  - On handshake, go to CHANGE if `balance>0`, else IDLE.
- **CHANGE**:
  - `change_value=balance`; hold `change_valid=1` until `change_ready`.
  - On handshake, set `balance<=0` and go to IDLE.
- **Busy states** (LOOKUP, EVAL, DISPENSE, CHANGE):
  - Any `currency_valid` pulses `currency_reject`.
  - `item_select_valid` and `cancel` are ignored.
- `dispense_valid` and `change_valid` are never high together.

## Timing
- Reset (`rstn=0` at a rising edge):
  - state IDLE, `balance=0`, timeout counter 0.
  - All outputs 0, including `price_rd_addr`, `dispense_item` and `change_value`.
  - Reset mid-transaction drops the handshakes and the credit at that edge. There is no refund.
- Currency accepted at edge N: `balance` is updated after N. `currency_reject` is high for the cycle after N.
- Item select sampled at edge N:
  - cycle N+1: LOOKUP, `price_rd_en=1`
  - edge N+2: EVAL samples the table outputs
  - cycle N+3: `dispense_valid=1`, or `vend_error=1` with the state back in CREDIT
- Handshakes complete on the edge where valid and ready are both 1. Valid drops in the next cycle.
- Zero-latency ready (ready already high) gives exactly one valid cycle.

## Configuration
- `VEND_TIMEOUT_EN` defined:
  - A counter runs while in CREDIT. It clears on entry to CREDIT and on every accepted note.
  - After `TIMEOUT_CYCLES` consecutive cycles with no accepted event, the next state is CHANGE, which refunds the full balance.
- Not defined: no counter exists and CREDIT persists indefinitely.

## Test plan
- Reset, then notes 50 and 20: `balance`=50, then 70. Select item 5 with price 60 in stock: `price_rd_en` at N+1, `dispense_valid` at N+3 with item 5, then after ready `change_value`=10, then IDLE with balance 0.
- Balance 30, select an item with price 40: `vend_error` one cycle, state CREDIT, balance 30. Repeat with price 20 but stock 0: `vend_error`, balance 30.
- Balance 950 (MAX_BALANCE 1000), insert 100: `currency_reject` pulse, balance stays 950.
- Balance 70 with `cancel` and `currency_valid` (value 10) in the same cycle: `currency_reject`, then CHANGE with `change_value`=70.
- Note during DISPENSE with `dispense_ready` held low for 5 cycles: `currency_reject`, `dispense_valid` held 5 cycles, balance unchanged.
- With `VEND_TIMEOUT_EN` and TIMEOUT_CYCLES=16: insert 40, then idle 16 cycles: `change_valid` with value 40. At 15 idle cycles plus a note, the counter restarts.
